// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: iCE40 PLL power-up/lock supervisor that holds system reset until lock is stable.
// Optional fallback to reference-clock bypass on repeated lock failure: define PLLSEQ_BYPASS_FALLBACK_EN.
module pll_reset_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 1000,
    parameter int STABLE_CYCLES = 64,
    parameter int MAX_RETRY     = 3,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       pll_lock,
    input  logic       restart,
    output logic       pll_resetb,
    output logic       pll_bypass,
    output logic       sys_rst_n,
    output logic       locked,
    output logic       fault,
    output logic [3:0] retry_cnt,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
`ifdef PLLSEQ_BYPASS_FALLBACK_EN
        ,
        ST_BYPASS    = 3'd5
`endif
    } state_t;

`ifdef PLLSEQ_BYPASS_FALLBACK_EN
    localparam state_t FAIL_STATE = ST_BYPASS;
`else
    localparam state_t FAIL_STATE = ST_FAULT;
`endif

    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRY);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [3:0]       retry_r;
    logic [3:0]       retry_nxt_s;
    logic             lock_meta_r;
    logic             lock_sync_r;
    logic             bypass_nxt_s;

    // Saturating increment: the counter parks at all-ones instead of wrapping.
    assign cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);

`ifdef PLLSEQ_BYPASS_FALLBACK_EN
    assign bypass_nxt_s = (state_nxt_s == ST_BYPASS);
`else
    assign bypass_nxt_s = 1'b0;
`endif

    assign state     = state_r;
    assign retry_cnt = retry_r;
    assign locked    = lock_sync_r;

    // Next-state, counter and retry logic; restart overrides every other condition.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_inc_s;
        retry_nxt_s = retry_r;
        if (restart) begin
            state_nxt_s = ST_RESET_PLL;
            cnt_nxt_s   = CNT_ZERO;
            retry_nxt_s = 4'd0;
        end else begin
            case (state_r)
                ST_RESET_PLL: begin
                    if (cnt_r == RST_LAST) begin
                        state_nxt_s = ST_WAIT_LOCK;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        state_nxt_s = ST_RESET_PLL;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_sync_r) begin
                        state_nxt_s = ST_STABLE;
                        cnt_nxt_s   = CNT_ZERO;
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        cnt_nxt_s = CNT_ZERO;
                        if (retry_r == RETRY_MAX) begin
                            state_nxt_s = FAIL_STATE;
                        end else begin
                            state_nxt_s = ST_RESET_PLL;
                            retry_nxt_s = retry_r + 4'd1;
                        end
                    end else begin
                        state_nxt_s = ST_WAIT_LOCK;
                    end
                end
                ST_STABLE: begin
                    // A lock glitch restarts the wait without costing a retry.
                    if (!lock_sync_r) begin
                        state_nxt_s = ST_WAIT_LOCK;
                        cnt_nxt_s   = CNT_ZERO;
                    end else if (cnt_r == STABLE_LAST) begin
                        state_nxt_s = ST_RUN;
                        cnt_nxt_s   = CNT_ZERO;
                        retry_nxt_s = 4'd0;
                    end else begin
                        state_nxt_s = ST_STABLE;
                    end
                end
                ST_RUN: begin
                    retry_nxt_s = 4'd0;
                    if (!lock_sync_r) begin
                        state_nxt_s = ST_RESET_PLL;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_FAULT: begin
                    state_nxt_s = ST_FAULT;
                end
`ifdef PLLSEQ_BYPASS_FALLBACK_EN
                ST_BYPASS: begin
                    state_nxt_s = ST_BYPASS;
                end
`endif
                default: begin
                    state_nxt_s = ST_RESET_PLL;
                    cnt_nxt_s   = CNT_ZERO;
                    retry_nxt_s = 4'd0;
                end
            endcase
        end
    end

    // State, counter, lock synchronizer and outputs decoded from the next state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_RESET_PLL;
            cnt_r       <= CNT_ZERO;
            retry_r     <= 4'd0;
            lock_meta_r <= 1'b0;
            lock_sync_r <= 1'b0;
            pll_resetb  <= 1'b0;
            pll_bypass  <= 1'b0;
            sys_rst_n   <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            retry_r     <= retry_nxt_s;
            lock_meta_r <= pll_lock;
            lock_sync_r <= lock_meta_r;
            pll_resetb  <= (state_nxt_s == ST_WAIT_LOCK) || (state_nxt_s == ST_STABLE) ||
                           (state_nxt_s == ST_RUN);
            pll_bypass  <= bypass_nxt_s;
            sys_rst_n   <= (state_nxt_s == ST_RUN) || bypass_nxt_s;
            fault       <= (state_nxt_s == ST_FAULT) || bypass_nxt_s;
        end
    end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Power-up and lock-supervision controller for the iCE40 PLL (SB_PLL40_CORE).
- Runs on the free-running HFOSC reference clock.
- Drives the PLL RESETB and BYPASS pins, watches LOCK, and holds system reset until lock has been stable for a programmed time.
- Retries the PLL on lock timeout and re-sequences on lock loss or a software restart request.
- Sits between SB_HFOSC/SB_PLL40_CORE and the reset tree of the timer core.

Parameters:
- RST_CYCLES, 16: cycles the PLL is held in reset per attempt (≥1).
- LOCK_TIMEOUT, 1000: cycles to wait for LOCK before retrying (≥1).
- STABLE_CYCLES, 64: consecutive synchronized-lock cycles required before releasing system reset (≥1).
- MAX_RETRY, 3: retries after the first attempt before declaring fault (0..15).
- CNT_W, 16: shared cycle-counter width; every cycle parameter must be < 2^CNT_W.

Ports:
- clk  in  1: reference clock (HFOSC output).
- resetn  in  1: asynchronous active-low reset.
- pll_lock  in  1: PLL LOCK, asynchronous to clk.
- restart  in  1: single-cycle software request to re-sequence.
- pll_resetb  out  1: to PLL RESETB, active low.
- pll_bypass  out  1: to PLL BYPASS.
- sys_rst_n  out  1: system reset for downstream logic, active low.
- locked  out  1: synchronized lock.
- fault  out  1: sticky fault flag; cleared by restart or resetn.
- retry_cnt  out  4: retries consumed in the current sequence.
- state  out  3: current FSM state.

Behaviour:
- Reset values (resetn low):
  - state=RESET_PLL, counter=0, retry_cnt=0.
  - pll_resetb=0, pll_bypass=0, sys_rst_n=0, fault=0, locked=0.
  - Both synchronizer flops = 0.
- pll_lock passes through a 2-flop synchronizer; lock_s has 2-cycle latency. locked = lock_s.
- All outputs are registered and decoded from the next state, so each output changes on the same edge as the state.
- State encodings: RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4, BYPASS=5.
- RESET_PLL:
  - pll_resetb=0.
  - Stays for exactly RST_CYCLES cycles, then goes to WAIT_LOCK with counter cleared.
- WAIT_LOCK:
  - pll_resetb=1.
  - If lock_s=1, go to STABLE and clear the counter.
  - Else, after LOCK_TIMEOUT cycles: if retry_cnt==MAX_RETRY go to FAULT; otherwise increment retry_cnt and go to RESET_PLL.
- STABLE:
  - If lock_s drops, go to WAIT_LOCK with the timeout counter restarted. This does not consume a retry.
  - After STABLE_CYCLES consecutive lock_s=1 cycles, go to RUN.
- RUN:
  - sys_rst_n=1 and retry_cnt cleared.
  - If lock_s=0, go to RESET_PLL; sys_rst_n is 0 on that same edge.
- FAULT:
  - fault=1, pll_resetb=0, sys_rst_n=0.
  - Terminal until restart or resetn.
- restart=1 in any state:
  - Next state is RESET_PLL, counter=0, retry_cnt=0, fault=0, sys_rst_n=0.
  - restart takes priority over lock loss and over timeout when they occur in the same cycle.
- Counter:
  - Single shared counter, cleared on every state change.
  - Saturates; it never wraps.
- resetn asserted mid-sequence: all outputs return to reset values immediately (asynchronously).
- With constant lock, sys_rst_n rises at edge RST_CYCLES+1+STABLE_CYCLES after resetn release, provided lock_s is already high.

Optional Feature:
- Macro: PLLSEQ_BYPASS_FALLBACK_EN.
- Defined:
  - Where FAULT would be entered, enter BYPASS instead: pll_bypass=1, pll_resetb=0, sys_rst_n=1, fault=1.
  - lock is ignored; only restart or resetn leave BYPASS.
  - The system runs directly on the reference clock.
- Not defined:
  - BYPASS state is absent and pll_bypass is tied 0.
  - State encoding 5 is unreachable.

Test Plan (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=2):
- Clean lock: pll_lock held 1, release resetn -> pll_resetb=0 for 4 cycles; sys_rst_n rises at edge 13; state=3; retry_cnt=0.
- Lock never asserts: pll_lock=0 -> three 24-cycle attempts; retry_cnt goes 1 then 2; fault=1 and state=4 at edge 72; sys_rst_n stays 0. With the macro defined: state=5, pll_bypass=1, sys_rst_n=1 at edge 72.
- Glitch in STABLE: lock drops for 1 cycle, 5 cycles into STABLE -> state returns to 1; retry_cnt unchanged; full 8 stable cycles required again before RUN.
- Lock loss in RUN: drop pll_lock -> sys_rst_n=0 and state=0 two cycles after the drop (synchronizer latency); sequence repeats; sys_rst_n rises again once lock returns.
- Restart: pulse restart in FAULT and separately in RUN -> next edge state=0, fault=0, retry_cnt=0, sys_rst_n=0. Restart coincident with lock loss -> still state=0 with counters cleared.
- Async reset mid-STABLE: assert resetn for a non-edge-aligned time -> outputs reset immediately, without waiting for a clk edge.
